calc1_port_driver: RTL

//  Upstream request driver for one calc1 port: buffers (cmd, op1, op2) transactions,

---
 rtl/calc1_port_driver_if.sv | 38 +++
 rtl/calc1_port_driver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver_if.sv
// Purpose: bundles the transaction, calc1 request/response and result signals of one calc1 port driver.
// Latency: none (wires only).
// Backpressure: txn_valid/txn_ready on the input side, res_valid/res_ready on the result side.
// Ports (slave = driver view):
//   txn_*  : transaction offered by upstream, txn_ready back-pressures
//   req_*  : serialised request toward calc1 reqN_cmd_in/reqN_data_in
//   calc_* : response from calc1 out_respN/out_dataN
//   res_*  : captured result, held until res_ready
interface calc1_port_driver_if;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_cmd;
    logic [31:0] txn_op1;
    logic [31:0] txn_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  calc_resp_in;
    logic [31:0] calc_data_in;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;

    modport slave (
        input  txn_valid, txn_cmd, txn_op1, txn_op2,
        input  calc_resp_in, calc_data_in, res_ready,
        output txn_ready, req_cmd_out, req_data_out,
        output res_valid, res_resp, res_data, res_timeout
    );

    modport master (
        output txn_valid, txn_cmd, txn_op1, txn_op2,
        output calc_resp_in, calc_data_in, res_ready,
        input  txn_ready, req_cmd_out, req_data_out,
        input  res_valid, res_resp, res_data, res_timeout
    );
endinterface

// File: rtl/calc1_port_driver.sv
// Purpose: buffers (cmd, op1, op2) transactions and drives them onto one calc1 port, returning the response.
// Latency: push at edge N puts cmd on the port after edge N+2 at the earliest; one request outstanding.
// Backpressure: txn_ready = !full (no bypass, no push on a full FIFO); result held until res_ready.
// Ports:
//   c_clk, reset : clock, asynchronous active-high reset (released synchronously inside)
//   port         : calc1_port_driver_if.slave (txn_*, req_*, calc_*, res_*)
//   busy         : FSM not IDLE or FIFO not empty
//   stray_resp   : sticky, nonzero calc_resp_in seen while no response was expected
module calc1_port_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                     c_clk,
    input  logic                     reset,
    calc1_port_driver_if.slave       port,
    output logic                     busy,
    output logic                     stray_resp
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE_OP1 = 3'd1;
    localparam logic [2:0] S_ISSUE_OP2 = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_RESULT    = 3'd4;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } txn_t;

    // Reset asserts asynchronously and releases two edges later, so every
    // flop below leaves reset on the same clock edge.
    logic rst_meta, rst_q;
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            rst_meta <= 1'b1;
            rst_q    <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_q    <= rst_meta;
        end
    end

    txn_t             mem [FIFO_DEPTH];
    txn_t             cur;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       req_cmd_q;
    logic [31:0]      req_data_q;
    logic             res_valid_q, res_timeout_q;
    logic [1:0]       res_resp_q;
    logic [31:0]      res_data_q;
    logic             do_push, do_pop, full;

    assign full    = (count == DEPTH_C);
    // Held low through reset and the release window as well.
    assign port.txn_ready = !rst_q && !full;
    // cmd 0 is a no-op: handshaked but never stored.
    assign do_push = port.txn_valid && port.txn_ready && (port.txn_cmd != 4'd0);
    assign do_pop  = (state == S_IDLE) && (count != '0);
    assign busy    = (state != S_IDLE) || (count != '0);

    assign port.req_cmd_out  = req_cmd_q;
    assign port.req_data_out = req_data_q;
    assign port.res_valid    = res_valid_q;
    assign port.res_resp     = res_resp_q;
    assign port.res_data     = res_data_q;
    assign port.res_timeout  = res_timeout_q;

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge c_clk) begin
        if (do_push)
            mem[wr_ptr] <= {port.txn_cmd, port.txn_op1, port.txn_op2};
    end

    always_ff @(posedge c_clk or posedge rst_q) begin
        if (rst_q) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The req_* registers are loaded with what the current state drives, so
    // the port shows cmd/op1 during ISSUE_OP2 and op2 during the first
    // WAIT_RESP cycle; each value is on the port for exactly one cycle.
    always_ff @(posedge c_clk or posedge rst_q) begin
        if (rst_q) begin
            state         <= S_IDLE;
            cur           <= '0;
            cnt           <= '0;
            req_cmd_q     <= '0;
            req_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_resp_q    <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (do_pop) begin
                        cur   <= mem[rd_ptr];
                        state <= S_ISSUE_OP1;
                    end
                end
                S_ISSUE_OP1: begin
                    req_cmd_q  <= cur.cmd;
                    req_data_q <= cur.op1;
                    state      <= S_ISSUE_OP2;
                end
                S_ISSUE_OP2: begin
                    req_cmd_q  <= '0;
                    req_data_q <= cur.op2;
                    cnt        <= '0;
                    state      <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    req_data_q <= '0;
                    // A response on the last counted cycle beats the timeout.
                    if (port.calc_resp_in != 2'd0) begin
                        res_valid_q   <= 1'b1;
                        res_resp_q    <= port.calc_resp_in;
                        res_data_q    <= port.calc_data_in;
                        res_timeout_q <= 1'b0;
                        state         <= S_RESULT;
                    end else if (cnt == CNT_LAST) begin
                        res_valid_q   <= 1'b1;
                        res_resp_q    <= '0;
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                        state         <= S_RESULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (port.res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_resp_q    <= '0;
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or posedge rst_q) begin
        if (rst_q)
            stray_resp <= 1'b0;
        else if ((state != S_WAIT_RESP) && (port.calc_resp_in != 2'd0))
            stray_resp <= 1'b1;
    end
endmodule
